// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default bit timing.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 208;
    localparam int CNT_W                = 12;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } rx_state_e;
`endif

endpackage

// File: rtl/line_sync.sv
// Two-flop synchroniser for the serial line plus a history flop for falling-edge detection.
module line_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       hist_q;
    logic [1:0] warm_q;

    // warm_q keeps the reset value of the pipeline from posing as an edge when
    // the line is already low as reset is released.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
            warm_q  <= 2'd0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign level_o = sync2_q;
    assign fall_o  = (warm_q == 2'd3) && hist_q && !sync2_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: 8N1 framing, or 8E1 when UART_RX_PARITY_EN is defined.
// Delivers bytes on a valid/ready output register with overrun and error pulses.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       line_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overrun_o,
    output logic       busy_o,
    output rx_state_e  state_o
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic level;
    logic fall;

    line_sync u_line_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .line_i  (line_i),
        .level_o (level),
        .fall_o  (fall)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q && !ready_i;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = level ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {level, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = level;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leaving at the mid-bit sample lets a following start edge be caught early.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = (^shift_q) ^ par_q;
`endif
                    if (!level) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || ready_i) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign state_o     = state_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer at CLKS_PER_BIT=8; define UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx_framer;
    import uart_pkg::*;

    localparam int CLKS = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       line = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;
    rx_state_e  state;

    uart_rx_framer #(.CLKS_PER_BIT(CLKS)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .line_i       (line),
        .ready_i      (ready),
        .data_o       (data),
        .valid_o      (valid),
        .frame_err_o  (frame_err),
        .parity_err_o (parity_err),
        .overrun_o    (overrun),
        .busy_o       (busy),
        .state_o      (state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // event monitor, sampled on the falling edge
    logic [7:0] got_q[$];
    int   valid_cycles = 0;
    int   busy_cycles  = 0;
    int   fe_cnt = 0;
    int   pe_cnt = 0;
    int   ov_cnt = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;
    int   stop_start = 0;
    logic last_par;

    always @(negedge clk) begin
        if (valid) valid_cycles++;
        if (busy) busy_cycles++;
        if (valid && !prev_valid) rise_cyc = cyc;
        prev_valid = valid;
        if (valid && ready) got_q.push_back(data);
        if (frame_err) fe_cnt++;
        if (parity_err) pe_cnt++;
        if (overrun) ov_cnt++;
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic par_bit, input int stop_len);
        last_par = par_bit;
        line = 1'b0;
        wait_cyc(CLKS);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            wait_cyc(CLKS);
        end
`ifdef UART_RX_PARITY_EN
        line = par_bit;
        wait_cyc(CLKS);
`endif
        stop_start = cyc;
        line = stop_bit;
        wait_cyc(stop_len);
        line = 1'b1;
    endtask

    // reference: even parity bit that makes the frame's ones count even
    function automatic logic even_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += b[i];
        return logic'(ones % 2);
    endfunction

    task automatic test_reset;
        int bc0;
        reset = 1'b1;
        line  = 1'b0;
        wait_cyc(3);
        n_checks++; if (data !== 8'h00) $display("FAIL reset_data: got %0h want 00", data); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_checks++;
        if ({frame_err, parity_err, overrun} !== 3'b000)
            $display("FAIL reset_pulses: got %03b want 000", {frame_err, parity_err, overrun});
        else n_pass++;
        // line held low across reset release must not look like a start edge
        bc0 = busy_cycles;
        reset = 1'b0;
        wait_cyc(40);
        n_checks++;
        if (busy_cycles - bc0 !== 0) $display("FAIL low_line_no_edge: busy cycles %0d want 0", busy_cycles - bc0);
        else n_pass++;
        line = 1'b1;
        wait_cyc(10);
    endtask

    task automatic test_single_a5;
        int vc0, fe0, pe0, ov0;
        got_q.delete();
        ready = 1'b1;
        vc0 = valid_cycles; fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        send_frame(8'hA5, 1'b1, even_par(8'hA5), CLKS);
        wait_cyc(12);
        n_checks++; if (got_q.size() !== 1) $display("FAIL a5_count: got %0d want 1", got_q.size()); else n_pass++;
        n_checks++;
        if (got_q.size() > 0 && got_q[0] !== 8'hA5) $display("FAIL a5_data: got %0h want a5", got_q[0]);
        else n_pass++;
        n_checks++;
        if (valid_cycles - vc0 !== 1) $display("FAIL a5_valid_len: got %0d want 1", valid_cycles - vc0);
        else n_pass++;
        n_checks++;
        if (fe_cnt - fe0 + pe_cnt - pe0 + ov_cnt - ov0 !== 0)
            $display("FAIL a5_no_err: got %0d pulses want 0", fe_cnt - fe0 + pe_cnt - pe0 + ov_cnt - ov0);
        else n_pass++;
        // stop bit middle is CLKS/2 cycles after it begins; valid follows 3 cycles later
        n_checks++;
        if (rise_cyc - stop_start !== CLKS / 2 + 3)
            $display("FAIL a5_latency: got %0d want %0d", rise_cyc - stop_start, CLKS / 2 + 3);
        else n_pass++;
    endtask

    task automatic test_false_start;
        int vc0, bc0;
        vc0 = valid_cycles; bc0 = busy_cycles;
        line = 1'b0;
        wait_cyc(3);
        line = 1'b1;
        wait_cyc(20);
        n_checks++;
        if (busy_cycles - bc0 < 1) $display("FAIL glitch_went_busy: busy cycles %0d want >0", busy_cycles - bc0);
        else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_low: got %0b want 0", busy); else n_pass++;
        n_checks++;
        if (valid_cycles - vc0 !== 0) $display("FAIL glitch_no_valid: got %0d want 0", valid_cycles - vc0);
        else n_pass++;
    endtask

    task automatic test_frame_err;
        int vc0, fe0;
        vc0 = valid_cycles; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, even_par(8'h3C), CLKS);
        wait_cyc(12);
        n_checks++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fe0); else n_pass++;
        n_checks++;
        if (valid_cycles - vc0 !== 0) $display("FAIL ferr_no_valid: got %0d want 0", valid_cycles - vc0);
        else n_pass++;
    endtask

    task automatic test_overrun;
        int ov0;
        got_q.delete();
        ov0 = ov_cnt;
        ready = 1'b0;
        send_frame(8'h11, 1'b1, even_par(8'h11), CLKS);
        wait_cyc(4);
        send_frame(8'h22, 1'b1, even_par(8'h22), CLKS);
        wait_cyc(6);
        n_checks++; if (data !== 8'h11) $display("FAIL ovr_data_held: got %0h want 11", data); else n_pass++;
        n_checks++; if (valid !== 1'b1) $display("FAIL ovr_valid_held: got %0b want 1", valid); else n_pass++;
        n_checks++; if (ov_cnt - ov0 !== 1) $display("FAIL ovr_pulse: got %0d want 1", ov_cnt - ov0); else n_pass++;
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
        n_checks++; if (valid !== 1'b0) $display("FAIL ovr_clear: got %0b want 0", valid); else n_pass++;
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h11) $display("FAIL ovr_taken: got %0d bytes want one 11", got_q.size());
        else n_pass++;
        ready = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b = 8'h5A;
        line = 1'b0;
        wait_cyc(CLKS);
        for (int i = 0; i < 4; i++) begin
            line = b[i];
            wait_cyc(CLKS);
        end
        line = b[4];
        wait_cyc(CLKS / 2);
        reset = 1'b1;
        wait_cyc(2);
        n_checks++;
        if ({data, valid, busy, frame_err, parity_err, overrun} !== 13'd0)
            $display("FAIL midrst_outputs: got data %0h valid %0b busy %0b pulses %03b want all 0",
                     data, valid, busy, {frame_err, parity_err, overrun});
        else n_pass++;
        reset = 1'b0;
        line = 1'b1;
        wait_cyc(10);
        got_q.delete();
        send_frame(8'h81, 1'b1, even_par(8'h81), CLKS);
        wait_cyc(12);
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h81)
            $display("FAIL midrst_next: got %0d bytes first %0h want one 81", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : 8'h00);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        int exp_fe;
        int fe0;
        logic [7:0] b;
        logic good;
        got_q.delete();
        fe0 = fe_cnt;
        exp_fe = 0;
        ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, good, even_par(b), $urandom_range(6, 10));
            if (good) exp_q.push_back(b);
            else exp_fe++;
            // a low stop bit must be followed by idle line before a new start edge can exist
            wait_cyc($urandom_range(0, 3) + (good ? 0 : 3));
        end
        wait_cyc(12);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) $display("FAIL rand_byte%0d: got %0h want %0h", k, got_q[k], exp_q[k]);
            else n_pass++;
        end
        n_checks++;
        if (fe_cnt - fe0 !== exp_fe) $display("FAIL rand_ferr: got %0d want %0d", fe_cnt - fe0, exp_fe);
        else n_pass++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int pe0, fe0;
        got_q.delete();
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h07, 1'b1, 1'b0, CLKS);
        wait_cyc(12);
        n_checks++; if (pe_cnt - pe0 !== 1) $display("FAIL par_pulse: got %0d want 1", pe_cnt - pe0); else n_pass++;
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h07) $display("FAIL par_data: got %0d bytes want one 07", got_q.size());
        else n_pass++;
        n_checks++; if (fe_cnt - fe0 !== 0) $display("FAIL par_no_ferr: got %0d want 0", fe_cnt - fe0); else n_pass++;
    endtask
`endif

    task automatic test_no_stray_parity;
        n_checks++;
`ifdef UART_RX_PARITY_EN
        if (pe_cnt !== 1) $display("FAIL parity_total: got %0d want 1", pe_cnt); else n_pass++;
`else
        if (pe_cnt !== 0) $display("FAIL parity_total: got %0d want 0", pe_cnt); else n_pass++;
`endif
    endtask

    initial begin
        wait_cyc(1);
        test_reset();
        test_single_a5();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_no_stray_parity();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: run exceeded time limit after %0d checks", n_checks);
        $fatal(1, "timeout");
    end

endmodule
